// File: rtl/sram_spi_port_pkg.sv
// Shared definitions for the SRAM-over-SPI port.
//   - SPI register addresses decoded by sram_spi_port
//   - transaction FSM state type
//   - bit positions inside sram_control_reg and sram_status
package sram_spi_port_pkg;

  localparam logic [6:0] REG_SRAM_CONTROL = 7'h07;
  localparam logic [6:0] REG_SRAM_ADDR    = 7'h08;
  localparam logic [6:0] REG_SPI_TO_SRAM  = 7'h09;
  localparam logic [6:0] REG_SRAM_TO_SPI  = 7'h0a;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_RD
  } state_e;

  // sram_control_reg fields
  localparam int unsigned CTRL_AUTO_INC = 7;
  localparam int unsigned CTRL_WRAP     = 6;

  // sram_status fields; bits [3:0] read as zero
  localparam int unsigned STAT_BUSY       = 7;
  localparam int unsigned STAT_PF_VALID   = 6;
  localparam int unsigned STAT_WR_OVERRUN = 5;
  localparam int unsigned STAT_TIMEOUT    = 4;

endpackage

// File: rtl/sram_addr_counter.sv
// Auto-incrementing SRAM byte-address counter.
//   clk, reset_n   : clock, asynchronous active-low reset (address -> 0)
//   load_i         : replace the address with load_addr_i (wins over increments)
//   inc_a_i/inc_b_i: independent increment requests; both in one cycle add two
//   auto_inc_i     : increments are ignored when low
//   wrap_i         : 1 = wrap the low byte only (page fixed), 0 = full-width wrap
//   addr_next_o    : value the counter takes on the next edge
module sram_addr_counter #(
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic          inc_a_i,
  input  logic          inc_b_i,
  input  logic          auto_inc_i,
  input  logic          wrap_i,
  output logic [AW-1:0] addr_next_o
);

  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] a, input logic in_page);
    logic [AW-1:0] r;
    if (in_page) r = {a[AW-1:8], a[7:0] + 8'd1};
    else         r = a + AW'(1);
    return r;
  endfunction

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_addr_i;
    end else if (auto_inc_i) begin
      if (inc_a_i) addr_d = bump(addr_d, wrap_i);
      if (inc_b_i) addr_d = bump(addr_d, wrap_i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) addr_q <= '0;
    else          addr_q <= addr_d;
  end

  assign addr_next_o = addr_d;

endmodule

// File: rtl/sram_spi_port.sv
// Bridges SPI register traffic to a single-byte req/ack SRAM port.
//   clk, reset_n            : clock, asynchronous active-low reset
//   spi_addr, wr_strobe,
//   rd_strobe               : register access from the SPI block
//   sram_control_reg        : [7] auto-increment, [6] in-page wrap, [PAGE_W-1:0] page
//   sram_start_addr_reg     : start byte within the page
//   spi_to_sram_reg         : byte to write
//   sram_to_spi_data        : prefetched read byte, valid when pf_valid
//   sram_status             : {busy, pf_valid, wr_overrun, timeout_err, 4'b0}
//   mem_req/mem_we/mem_addr/
//   mem_wdata               : request side, held stable while mem_req is high
//   mem_ack/mem_rdata       : one-cycle completion with read data
module sram_spi_port
  import sram_spi_port_pkg::*;
#(
  parameter int unsigned PAGE_W      = 4,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [6:0]        spi_addr,
  input  logic              wr_strobe,
  input  logic              rd_strobe,
  input  logic [7:0]        sram_control_reg,
  input  logic [7:0]        sram_start_addr_reg,
  input  logic [7:0]        spi_to_sram_reg,
  output logic [7:0]        sram_to_spi_data,
  output logic [7:0]        sram_status,
  output logic              mem_req,
  output logic              mem_we,
  output logic [PAGE_W+7:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata
);

  localparam int unsigned AW   = PAGE_W + 8;
  localparam int unsigned TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            load_evt_q, load_evt_d;
  logic            wr_evt_q, wr_evt_d;
  logic            rd_evt_q, rd_evt_d;
  logic            wr_pend_q, wr_pend_d;
  logic            pf_pend_q, pf_pend_d;
  logic            pf_valid_q, pf_valid_d;
  logic            wr_overrun_q, wr_overrun_d;
  logic            timeout_err_q, timeout_err_d;
  logic            disc_q, disc_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic            mem_we_q, mem_we_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  logic            cnt_inc_wr;
  logic [AW-1:0]   addr_next;
  logic            to_expired;
  logic            rd_stale;
  logic            busy;
  logic            unused_ctrl;

  // Only the page field and the two mode bits are meaningful here.
  assign unused_ctrl = ^sram_control_reg;

  // Source registers update on the strobe edge, so events act a cycle later.
  always_comb begin
    load_evt_d = wr_strobe && ((spi_addr == REG_SRAM_CONTROL) || (spi_addr == REG_SRAM_ADDR));
    wr_evt_d   = wr_strobe && (spi_addr == REG_SPI_TO_SRAM);
    rd_evt_d   = rd_strobe && (spi_addr == REG_SRAM_TO_SPI);
  end

  assign cnt_inc_wr = (state_q == ST_WR) && mem_ack;

  sram_addr_counter #(
    .AW(AW)
  ) u_addr_counter (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_i      (load_evt_q),
    .load_addr_i ({sram_control_reg[PAGE_W-1:0], sram_start_addr_reg}),
    .inc_a_i     (cnt_inc_wr),
    .inc_b_i     (rd_evt_q),
    .auto_inc_i  (sram_control_reg[CTRL_AUTO_INC]),
    .wrap_i      (sram_control_reg[CTRL_WRAP]),
    .addr_next_o (addr_next)
  );

  assign to_expired = (to_cnt_q == TO_LAST);
  // A read returning in the same cycle as a load or SPI read is already stale.
  assign rd_stale   = disc_q | load_evt_q | rd_evt_q;

  always_comb begin
    state_d       = state_q;
    wr_pend_d     = wr_pend_q;
    pf_pend_d     = pf_pend_q;
    pf_valid_d    = pf_valid_q;
    wr_overrun_d  = wr_overrun_q;
    timeout_err_d = timeout_err_q;
    disc_d        = disc_q;
    rd_data_d     = rd_data_q;
    wr_data_d     = wr_data_q;
    mem_addr_d    = mem_addr_q;
    mem_we_d      = mem_we_q;
    to_cnt_d      = to_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        to_cnt_d = '0;
        // Request fields come from the counter's next value so a load
        // landing on the issue edge is already reflected.
        if (wr_pend_q) begin
          state_d    = ST_WR;
          mem_we_d   = 1'b1;
          mem_addr_d = addr_next;
        end else if (pf_pend_q) begin
          state_d    = ST_RD;
          mem_we_d   = 1'b0;
          mem_addr_d = addr_next;
        end
      end
      ST_WR: begin
        if (mem_ack) begin
          wr_pend_d  = 1'b0;
          pf_valid_d = 1'b0;
          pf_pend_d  = 1'b1;
          state_d    = ST_IDLE;
        end else if (to_expired) begin
          wr_pend_d     = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_RD: begin
        if (mem_ack) begin
          if (!rd_stale) begin
            rd_data_d  = mem_rdata;
            pf_valid_d = 1'b1;
            pf_pend_d  = 1'b0;
          end
          disc_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (to_expired) begin
          pf_pend_d     = 1'b0;
          timeout_err_d = 1'b1;
          disc_d        = 1'b0;
          state_d       = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // SPI events are applied after the FSM so they override its flag updates.
    if (load_evt_q) begin
      pf_valid_d    = 1'b0;
      pf_pend_d     = 1'b1;
      wr_overrun_d  = 1'b0;
      timeout_err_d = 1'b0;
      if ((state_q == ST_RD) && (state_d == ST_RD)) disc_d = 1'b1;
    end

    if (wr_evt_q) begin
      if (wr_pend_q || (state_q == ST_WR)) begin
        wr_overrun_d = 1'b1;
      end else begin
        wr_data_d = spi_to_sram_reg;
        wr_pend_d = 1'b1;
      end
    end

    if (rd_evt_q) begin
      pf_valid_d = 1'b0;
      pf_pend_d  = 1'b1;
      if ((state_q == ST_RD) && (state_d == ST_RD)) disc_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      load_evt_q    <= 1'b0;
      wr_evt_q      <= 1'b0;
      rd_evt_q      <= 1'b0;
      wr_pend_q     <= 1'b0;
      pf_pend_q     <= 1'b0;
      pf_valid_q    <= 1'b0;
      wr_overrun_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      disc_q        <= 1'b0;
      rd_data_q     <= '0;
      wr_data_q     <= '0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      load_evt_q    <= load_evt_d;
      wr_evt_q      <= wr_evt_d;
      rd_evt_q      <= rd_evt_d;
      wr_pend_q     <= wr_pend_d;
      pf_pend_q     <= pf_pend_d;
      pf_valid_q    <= pf_valid_d;
      wr_overrun_q  <= wr_overrun_d;
      timeout_err_q <= timeout_err_d;
      disc_q        <= disc_d;
      rd_data_q     <= rd_data_d;
      wr_data_q     <= wr_data_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  assign busy = (state_q != ST_IDLE) | wr_pend_q | pf_pend_q;

  always_comb begin
    sram_status                  = '0;
    sram_status[STAT_BUSY]       = busy;
    sram_status[STAT_PF_VALID]   = pf_valid_q;
    sram_status[STAT_WR_OVERRUN] = wr_overrun_q;
    sram_status[STAT_TIMEOUT]    = timeout_err_q;
  end

  // mem_req is decoded from the state flop so reset removes it immediately.
  assign mem_req          = (state_q != ST_IDLE);
  assign mem_we           = mem_we_q;
  assign mem_addr         = mem_addr_q;
  assign mem_wdata        = wr_data_q;
  assign sram_to_spi_data = rd_data_q;

endmodule

// File: tb/tb_sram_spi_port.sv
module tb_sram_spi_port;

  localparam int unsigned PAGE_W = 4;
  localparam int unsigned AW     = PAGE_W + 8;
  localparam int unsigned TO     = 8;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } txn_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [6:0]    spi_addr = '0;
  logic          wr_strobe = 1'b0;
  logic          rd_strobe = 1'b0;
  logic [7:0]    ctrl_reg = '0;
  logic [7:0]    start_reg = '0;
  logic [7:0]    wdata_reg = '0;
  logic [7:0]    sram_to_spi_data;
  logic [7:0]    sram_status;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_ack = 1'b0;
  logic [7:0]    mem_rdata = '0;

  always #5 clk = ~clk;

  sram_spi_port #(
    .PAGE_W(PAGE_W),
    .ACK_TIMEOUT(TO)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .spi_addr            (spi_addr),
    .wr_strobe           (wr_strobe),
    .rd_strobe           (rd_strobe),
    .sram_control_reg    (ctrl_reg),
    .sram_start_addr_reg (start_reg),
    .spi_to_sram_reg     (wdata_reg),
    .sram_to_spi_data    (sram_to_spi_data),
    .sram_status         (sram_status),
    .mem_req             (mem_req),
    .mem_we              (mem_we),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_ack             (mem_ack),
    .mem_rdata           (mem_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  function automatic logic [7:0] init_byte(input int unsigned i);
    return 8'((i * 29 + 7) ^ (i >> 3));
  endfunction

  // SRAM responder: acks after a programmable delay, logs every completion.
  logic [7:0] mem [1 << AW];
  txn_t       obs_q[$];
  bit         responder_en = 1'b1;
  int         fixed_delay  = -1;

  initial begin
    bit prev_req;
    int cnt;
    txn_t t;
    prev_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = init_byte(i);
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!mem_req) begin
        prev_req = 1'b0;
      end else begin
        if (!prev_req) begin
          cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
          prev_req = 1'b1;
        end
        if (responder_en) begin
          if (cnt == 0) begin
            mem_ack = 1'b1;
            t.we = mem_we;
            t.addr = mem_addr;
            if (mem_we) begin
              mem[mem_addr] = mem_wdata;
              t.data = mem_wdata;
            end else begin
              mem_rdata = mem[mem_addr];
              t.data = mem_rdata;
            end
            obs_q.push_back(t);
            cnt = -1;
          end else if (cnt > 0) begin
            cnt--;
          end
        end
      end
    end
  end

  // Reference model: address pointer and flags derived from the register rules.
  logic [7:0]    exp_mem [1 << AW];
  txn_t          exp_q[$];
  int            obs_idx = 0;
  logic [AW-1:0] m_addr = '0;
  logic          m_pfv = 1'b0;
  logic          m_ovr = 1'b0;
  logic          m_to  = 1'b0;
  logic [7:0]    m_data = '0;

  function automatic logic [AW-1:0] m_next(input logic [AW-1:0] a);
    if (!ctrl_reg[7]) return a;
    if (ctrl_reg[6])  return {a[AW-1:8], 8'(a[7:0] + 8'd1)};
    return AW'(a + 1);
  endfunction

  task automatic expect_read();
    m_data = exp_mem[m_addr];
    m_pfv  = 1'b1;
    exp_q.push_back({1'b0, m_addr, m_data});
  endtask

  task automatic strobe(input logic [6:0] a, input bit is_wr);
    @(negedge clk);
    spi_addr = a;
    if (is_wr) wr_strobe = 1'b1;
    else       rd_strobe = 1'b1;
    @(negedge clk);
    wr_strobe = 1'b0;
    rd_strobe = 1'b0;
  endtask

  task automatic wait_idle();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      if (!sram_status[7]) break;
      @(negedge clk);
    end
    check("idle_wait_busy", 32'(sram_status[7]), 0);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 50; i++) begin
      if (mem_req) break;
      @(negedge clk);
    end
    check("req_seen", 32'(mem_req), 1);
  endtask

  task automatic check_state(input string tag);
    int n_obs;
    check({tag, "_status"}, 32'(sram_status), 32'({1'b0, m_pfv, m_ovr, m_to, 4'b0}));
    if (m_pfv) check({tag, "_rdata"}, 32'(sram_to_spi_data), 32'(m_data));
    n_obs = obs_q.size() - obs_idx;
    check({tag, "_txn_count"}, 32'(n_obs), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < n_obs)
        check($sformatf("%s_txn%0d", tag, i), 32'(obs_q[obs_idx + i]), 32'(exp_q[i]));
    obs_idx = obs_q.size();
    exp_q.delete();
  endtask

  task automatic do_load(input logic [7:0] ctrl, input logic [7:0] start, input bit via_ctrl);
    ctrl_reg  = ctrl;
    start_reg = start;
    strobe(via_ctrl ? 7'h07 : 7'h08, 1'b1);
    m_addr = {ctrl[PAGE_W-1:0], start};
    m_ovr  = 1'b0;
    m_to   = 1'b0;
    expect_read();
    wait_idle();
    check_state("load");
  endtask

  task automatic do_write(input logic [7:0] b);
    wdata_reg = b;
    strobe(7'h09, 1'b1);
    exp_q.push_back({1'b1, m_addr, b});
    exp_mem[m_addr] = b;
    m_addr = m_next(m_addr);
    expect_read();
    wait_idle();
    check_state("write");
  endtask

  task automatic do_read();
    @(negedge clk);
    check("pre_read_valid", 32'(sram_status[6]), 1);
    check("pre_read_data", 32'(sram_to_spi_data), 32'(m_data));
    strobe(7'h0a, 1'b0);
    m_addr = m_next(m_addr);
    expect_read();
    wait_idle();
    check_state("read");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < (1 << AW); i++) exp_mem[i] = init_byte(i);

    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({mem_req, mem_we, mem_addr, mem_wdata}), 0);
    check("reset_data_status", 32'({sram_to_spi_data, sram_status}), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Load then prefetch with a 3-cycle ack.
    fixed_delay = 3;
    do_load(8'h81, 8'h10, 1'b1);

    // Burst write.
    fixed_delay = -1;
    do_write(8'h11);
    repeat (12) @(negedge clk);
    do_write(8'h22);
    repeat (12) @(negedge clk);
    do_write(8'h33);

    // In-page wrap, then full-width carry into the next page.
    do_load(8'hC1, 8'hFF, 1'b0);
    do_read();
    do_load(8'h81, 8'hFF, 1'b0);
    do_read();

    // Overrun: second byte arrives while the first write awaits ack.
    do_load(8'h81, 8'h40, 1'b0);
    fixed_delay = 4;
    wdata_reg = 8'h44;
    strobe(7'h09, 1'b1);
    wait_req();
    wdata_reg = 8'h99;
    strobe(7'h09, 1'b1);
    exp_q.push_back({1'b1, m_addr, 8'h44});
    exp_mem[m_addr] = 8'h44;
    m_addr = m_next(m_addr);
    expect_read();
    m_ovr = 1'b1;
    wait_idle();
    check_state("overrun");
    fixed_delay = -1;
    do_read();

    // Timeout: no ack at all.
    responder_en = 1'b0;
    ctrl_reg  = 8'h81;
    start_reg = 8'h30;
    strobe(7'h08, 1'b1);
    wait_req();
    n = 0;
    while (mem_req && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("timeout_req_cycles", 32'(n), TO);
    m_addr = {4'h1, 8'h30};
    m_ovr = 1'b0;
    m_to  = 1'b1;
    m_pfv = 1'b0;
    wait_idle();
    check_state("timeout");
    responder_en = 1'b1;
    do_write(8'h5A);

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        logic [7:0] c, s;
        case ($urandom_range(0, 2))
          0:       c = 8'h80;
          1:       c = 8'hC0;
          default: c = 8'h00;
        endcase
        c = c | 8'($urandom_range(0, 15));
        s = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
        do_load(c, s, $urandom_range(0, 1) == 1);
      end else if (r < 6 || !m_pfv) begin
        do_write(8'($urandom));
      end else begin
        do_read();
      end
    end

    // Load while a read is in flight: old data discarded, re-read at new start.
    fixed_delay = 4;
    ctrl_reg  = 8'h81;
    start_reg = 8'h10;
    strobe(7'h08, 1'b1);
    wait_req();
    start_reg = 8'h20;
    strobe(7'h08, 1'b1);
    m_addr = {4'h1, 8'h10};
    expect_read();
    m_addr = {4'h1, 8'h20};
    m_ovr = 1'b0;
    m_to  = 1'b0;
    expect_read();
    wait_idle();
    check_state("load_during_read");

    // Reset in the middle of a request.
    ctrl_reg  = 8'h81;
    start_reg = 8'h50;
    strobe(7'h08, 1'b1);
    wait_req();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_mid_req", 32'(mem_req), 0);
    check("rst_mid_outputs", 32'({mem_we, mem_addr, mem_wdata}), 0);
    check("rst_mid_data_status", 32'({sram_to_spi_data, sram_status}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    m_addr = '0;
    m_pfv = 1'b0;
    m_ovr = 1'b0;
    m_to  = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("post_reset_status", 32'(sram_status), 0);
    obs_idx = obs_q.size();
    fixed_delay = -1;
    do_load(8'h83, 8'h05, 1'b1);
    do_write(8'hC3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_spi_port.md
Name: sram_spi_port

Overview:
- Sits directly downstream of the SPI register block.
- Turns the SRAM_CONTROL (0x07), SRAM_ADDR (0x08), SPI_TO_SRAM (0x09) and SRAM_TO_SPI (0x0a) register traffic into single-byte req/ack transactions on the SRAM controller port.
- Keeps an auto-incrementing address and a one-byte read prefetch, so sram_to_spi_data is already valid when the SPI block samples it on rd_strobe.

Parameters:
- PAGE_W, 4, page bits taken from sram_control_reg[PAGE_W-1:0]; memory address width = PAGE_W+8.
- ACK_TIMEOUT, 255, cycles to wait for mem_ack before aborting; minimum 2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- spi_addr  in  7  register address from SPI block
- wr_strobe  in  1  one-cycle SPI write strobe
- rd_strobe  in  1  one-cycle SPI read strobe
- sram_control_reg  in  8  [7]=auto-increment enable, [6]=wrap within page, [PAGE_W-1:0]=page
- sram_start_addr_reg  in  8  start byte address within page
- spi_to_sram_reg  in  8  write data byte
- sram_to_spi_data  out  8  prefetched read byte
- sram_status  out  8  {busy, pf_valid, wr_overrun, timeout_err, 4'b0}
- mem_req  out  1  request; held high until mem_ack or timeout
- mem_we  out  1  1=write, 0=read; stable while mem_req is high
- mem_addr  out  PAGE_W+8  byte address; stable while mem_req is high
- mem_wdata  out  8  write byte; stable while mem_req is high
- mem_ack  in  1  one-cycle completion; mem_rdata valid in the same cycle
- mem_rdata  in  8  read byte

Behaviour:
- Reset: all outputs 0. Address counter = 0, FSM = IDLE, pending flags clear, pf_valid = 0.
- Events are registered one cycle after the strobe, because the source registers update on the strobe edge:
  - load_evt: wr_strobe on 0x07 or 0x08.
  - wr_evt: wr_strobe on 0x09.
  - rd_evt: rd_strobe on 0x0a.
- load_evt:
  - addr = {page, sram_start_addr_reg}; pf_valid = 0; pf_pend = 1; wr_overrun and timeout_err cleared.
  - If a read is in flight, its returned data is discarded.
- wr_evt:
  - If wr_pend is already 1 or a write is in flight, set wr_overrun (sticky) and drop the new byte.
  - Otherwise latch the byte and set wr_pend.
- rd_evt:
  - The SPI block has already captured sram_to_spi_data on the strobe edge.
  - Clear pf_valid, increment the address, set pf_pend.
- Write completion (ack): increment the address, clear pf_valid, set pf_pend. The prefetch follows the write pointer.
- Address increment applies only when sram_control_reg[7]=1; otherwise the address holds.
  - [6]=1: low 8 bits wrap 0xFF->0x00 and the page is unchanged.
  - [6]=0: full-width increment, wrapping at all ones -> 0.
- FSM states:
  - IDLE: if wr_pend, go to WR (write has priority); else if pf_pend, go to RD. mem_req asserts on the entry edge.
  - WR: hold mem_req, mem_we=1. On mem_ack: wr_pend=0, go to IDLE.
  - RD: hold mem_req, mem_we=0. On mem_ack: if not discarded, sram_to_spi_data=mem_rdata, pf_valid=1, pf_pend=0; go to IDLE. If discarded, pf_pend stays 1 and the read is re-issued.
  - WR/RD timeout: timeout counter reaches ACK_TIMEOUT with no ack -> drop mem_req, set timeout_err, clear the active pending flag, go to IDLE. The address is not incremented.
- Request latency: mem_req rises 2 cycles after the strobe when IDLE.
- mem_ack outside WR/RD is ignored.
- busy = (state != IDLE) | wr_pend | pf_pend.
- Simultaneous events in one cycle:
  - load_evt and wr_evt: the load is applied first, so the write goes to the new start address.
  - rd_evt and mem_ack: both take effect; the increment is applied once per event.
- Reset mid-transaction: mem_req drops immediately (asynchronous) and all state clears.

Decomposition:
- Shared package holds:
  - the register address constants 0x07–0x0a;
  - the FSM state enum {IDLE, WR, RD};
  - the sram_status bit indices.
- One sub-module, sram_addr_counter: load, increment, auto-inc enable and wrap mode. Everything else stays flat.

Test Plan:
- Load, then prefetch:
  - Stimulus: control=0x81, start=0x10; memory[0x110]=0xA5; ack 3 cycles after req.
  - Required: read req at 0x110, then sram_to_spi_data=0xA5 and pf_valid=1.
- Burst write:
  - Stimulus: three wr_evt with 0x11, 0x22, 0x33, spaced 20 cycles apart.
  - Required: writes to 0x110, 0x111, 0x112; prefetch re-issued at 0x113 after the last write.
- Wrap:
  - Stimulus: start=0xFF, control=0xC1, one rd_evt.
  - Required: next prefetch at 0x100.
  - Repeat with control=0x81: required prefetch at 0x200.
- Overrun:
  - Stimulus: second wr_evt while the first write is awaiting ack.
  - Required: only the first byte is written; sram_status[5]=1 until the next load_evt.
- Timeout:
  - Stimulus: never ack, ACK_TIMEOUT=8.
  - Required: mem_req drops after 8 cycles, sram_status[4]=1, address unchanged, FSM returns to IDLE.
- Load during read, then reset:
  - Stimulus: load_evt to 0x20 while a read at 0x110 is in flight.
  - Required: the 0x110 data is discarded; re-read at 0x120 (page 1).
  - Then assert reset_n low mid-request: required mem_req=0 in the same cycle and all outputs 0.
